// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard/stall sequencer.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int REG_AW_DEF       = 5;
    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int MEM_TIMEOUT_DEF  = 255;
    localparam int WAIT_W           = 8;

    typedef logic [WAIT_W-1:0] wait_cnt_t;

    function automatic wait_cnt_t wait_inc_sat(input wait_cnt_t c);
        return (c == '1) ? c : c + wait_cnt_t'(1);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the EX load's destination matches a source the ID instruction reads.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_rd,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_rd && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer: load-use stalls, branch-flush bubbles, dmem-busy freeze.
// Optional macro STALL_CNT_EN adds a 32-bit bubble-cycle counter on stall_count.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_rd,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_br_taken,
    input  logic              dmem_busy,
    output logic              mux_stall_sel,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              pipe_hold,
    output logic              mem_timeout_err,
    output logic [31:0]       stall_count
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t         state, state_next;
    logic [FCW-1:0] flush_cnt, flush_cnt_next;
    wait_cnt_t      wait_cnt, wait_sat;
    logic           load_use;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_mem_rd  (ex_mem_rd),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    assign wait_sat = wait_inc_sat(wait_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            flush_cnt       <= '0;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            wait_cnt  <= dmem_busy ? wait_sat : '0;
            if (dmem_busy && (wait_sat >= wait_cnt_t'(MEM_TIMEOUT)))
                mem_timeout_err <= 1'b1;
        end
    end

    // Priority: memory freeze, then flush/branch, then load-use
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        mux_stall_sel  = 1'b1;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        pipe_hold      = 1'b0;

        if (dmem_busy) begin
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (state == FLUSH) begin
            if_id_flush    = 1'b1;
            mux_stall_sel  = 1'b0;
            flush_cnt_next = flush_cnt - FCW'(1);
            if (flush_cnt == FCW'(1))
                state_next = RUN;
        end else if (ex_br_taken) begin
            if_id_flush   = 1'b1;
            mux_stall_sel = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                state_next     = FLUSH;
                flush_cnt_next = FCW'(FLUSH_CYCLES - 1);
            end
        end else if (load_use) begin
            mux_stall_sel = 1'b0;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= 32'd0;
        else if (!mux_stall_sel && !dmem_busy)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (default parameters).
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_rd, ex_br_taken, dmem_busy;
    logic        mux_stall_sel, pc_write, if_id_write, if_id_flush, pipe_hold;
    logic        mem_timeout_err;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Control vector order: {mux_stall_sel, pc_write, if_id_write, if_id_flush, pipe_hold}
    localparam logic [4:0] CTRL_IDLE   = 5'b11100;
    localparam logic [4:0] CTRL_LOADUSE = 5'b00000;
    localparam logic [4:0] CTRL_BUBBLE = 5'b01110;
    localparam logic [4:0] CTRL_HOLD   = 5'b10001;

`ifdef STALL_CNT_EN
    localparam logic [31:0] EXP_STALLS = 32'd3;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

    hazard_stall_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_mem_rd       (ex_mem_rd),
        .ex_rd           (ex_rd),
        .ex_br_taken     (ex_br_taken),
        .dmem_busy       (dmem_busy),
        .mux_stall_sel   (mux_stall_sel),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .pipe_hold       (pipe_hold),
        .mem_timeout_err (mem_timeout_err),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic br, input logic busy, input logic mrd,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use1, input logic use2);
        ex_br_taken = br;
        dmem_busy   = busy;
        ex_mem_rd   = mrd;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs1  = use1;
        id_use_rs2  = use2;
        #2;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctrlVec();
        return {27'd0, mux_stall_sel, pc_write, if_id_write, if_id_flush, pipe_hold};
    endfunction

    initial begin
        rst_n = 1'b0;
        applyIdle();
        checkOutput("reset_ctrl", ctrlVec(), {27'd0, CTRL_IDLE});
        checkOutput("reset_err", {31'd0, mem_timeout_err}, 32'd0);
        checkOutput("reset_count", stall_count, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Load-use on rs1, then released next cycle
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0);
        checkOutput("lu_rs1", ctrlVec(), {27'd0, CTRL_LOADUSE});
        step();
        applyIdle();
        checkOutput("lu_release", ctrlVec(), {27'd0, CTRL_IDLE});
        step();

        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        checkOutput("lu_x0", ctrlVec(), {27'd0, CTRL_IDLE});
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
        checkOutput("lu_unused", ctrlVec(), {27'd0, CTRL_IDLE});
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
        checkOutput("lu_rs2", ctrlVec(), {27'd0, CTRL_LOADUSE});
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd7, 5'd6, 5'd8, 1'b1, 1'b1);
        checkOutput("lu_nomatch", ctrlVec(), {27'd0, CTRL_IDLE});
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
        checkOutput("lu_notload", ctrlVec(), {27'd0, CTRL_IDLE});
        step();

        // Branch coinciding with load-use: branch wins; second-cycle branch ignored
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        checkOutput("br_cyc1", ctrlVec(), {27'd0, CTRL_BUBBLE});
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        checkOutput("br_cyc2", ctrlVec(), {27'd0, CTRL_BUBBLE});
        step();
        applyIdle();
        checkOutput("br_done", ctrlVec(), {27'd0, CTRL_IDLE});
        step();

        // dmem_busy for 3 cycles in the middle of a flush
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("brb_cyc1", ctrlVec(), {27'd0, CTRL_BUBBLE});
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
            checkOutput($sformatf("brb_hold%0d", i), ctrlVec(), {27'd0, CTRL_HOLD});
            step();
        end
        applyIdle();
        checkOutput("brb_resume", ctrlVec(), {27'd0, CTRL_BUBBLE});
        step();
        applyIdle();
        checkOutput("brb_done", ctrlVec(), {27'd0, CTRL_IDLE});
        checkOutput("brb_err", {31'd0, mem_timeout_err}, 32'd0);
        step();

        // Memory-wait timeout after 255 consecutive busy cycles
        for (int i = 0; i < 254; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            step();
        end
        checkOutput("to_254", {31'd0, mem_timeout_err}, 32'd0);
        checkOutput("to_hold", ctrlVec(), {27'd0, CTRL_HOLD});
        step();
        checkOutput("to_255", {31'd0, mem_timeout_err}, 32'd1);
        step();
        applyIdle();
        checkOutput("to_sticky", {31'd0, mem_timeout_err}, 32'd1);
        checkOutput("to_release", ctrlVec(), {27'd0, CTRL_IDLE});
        step();
        checkOutput("to_sticky2", {31'd0, mem_timeout_err}, 32'd1);

        // Asynchronous reset in the middle of a flush
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        applyIdle();
        checkOutput("rf_inflush", ctrlVec(), {27'd0, CTRL_BUBBLE});
        rst_n = 1'b0;
        #1;
        checkOutput("rf_async", ctrlVec(), {27'd0, CTRL_IDLE});
        checkOutput("rf_errclr", {31'd0, mem_timeout_err}, 32'd0);
        checkOutput("rf_cntclr", stall_count, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        applyIdle();
        checkOutput("rf_nopending", ctrlVec(), {27'd0, CTRL_IDLE});
        step();

        // Three load-use stalls for the bubble counter
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 5'd12, 5'd12, 5'd1, 1'b1, 1'b1);
            checkOutput($sformatf("cnt_stall%0d", i), ctrlVec(), {27'd0, CTRL_LOADUSE});
            step();
            applyIdle();
            step();
        end
        checkOutput("cnt_final", stall_count, EXP_STALLS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
